ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 85 ++++++++
 tb/tb_ifetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch FSM with memory handshake, next-PC selection, link and retire counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Addr_Result,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic        instr_valid,
    output logic [31:0] branch_base_addr,
    output logic [31:0] link_addr,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, ISSUE} state_t;
    state_t state, next_state;
    logic [31:0] pc, pc4, target, next_pc;
    logic capture, advance, taken;

    always_comb begin
        pc4     = pc + 32'd4;
        taken   = (Branch && Zero) || (nBranch && !Zero);
        target  = Jr ? Read_data_1 :
                  (Jmp || Jal) ? {pc4[31:28], Instruction[25:0], 2'b00} :
                  taken ? Addr_Result : pc4;
        next_pc = {target[31:2], 2'b00};
        // valid only counts while a request is outstanding or being accepted
        capture = (state == FETCH && imem_ready && imem_valid) || (state == WAIT && imem_valid);
        advance = state == ISSUE && !hold;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH:   next_state = imem_ready ? (imem_valid ? ISSUE : WAIT) : FETCH;
            WAIT:    next_state = imem_valid ? ISSUE : WAIT;
            default: next_state = hold ? ISSUE : FETCH;
        endcase
    end

    always_comb begin
        imem_req         = state == FETCH;
        imem_addr        = pc;
        instr_valid      = state == ISSUE;
        branch_base_addr = pc4;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            Instruction <= 32'd0;
            link_addr   <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            if (capture)
                Instruction <= imem_rdata;
            if (advance) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
                if (Jal)
                    link_addr <= pc4;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Addr_Result = '0;
    logic        Zero = 1'b0;
    logic [31:0] Read_data_1 = '0;
    logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0;
    logic        hold = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic [31:0] branch_base_addr;
    logic [31:0] link_addr;
    logic [31:0] instr_count;
    int checks = 0;
    int errors = 0;

    ifetch_unit dut (
        .clock(clock), .reset(reset), .Addr_Result(Addr_Result), .Zero(Zero),
        .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp),
        .Jal(Jal), .Jr(Jr), .hold(hold), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .instr_valid(instr_valid),
        .branch_base_addr(branch_base_addr), .link_addr(link_addr), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // expects FETCH at addr; memory answers one cycle after acceptance
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        chk("fetch_ivalid", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
        chk("issue_ivalid", {31'd0, instr_valid}, 32'd1);
        chk("issue_instr", Instruction, word);
        chk("issue_bba", branch_base_addr, addr + 32'd4);
    endtask

    task automatic issue(input logic jr, input logic [31:0] rd1, input logic jal,
                         input logic br, input logic nbr, input logic z, input logic [31:0] ar);
        Jr = jr; Read_data_1 = rd1; Jal = jal; Branch = br; nBranch = nbr; Zero = z; Addr_Result = ar;
        hold = 1'b0;
        tick();
        Jr = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_link", link_addr, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_bba", branch_base_addr, 32'd4);
        reset = 1'b0;
        chk("rel_req", {31'd0, imem_req}, 32'd0);
        tick();
        // sequential fetch
        fetch(32'h0, 32'h1111_0000);
        issue(0, 0, 0, 0, 0, 0, 0);
        fetch(32'h4, 32'h1111_0004);
        issue(0, 0, 0, 0, 0, 0, 0);
        fetch(32'h8, 32'h1111_0008);
        issue(0, 0, 0, 0, 0, 0, 0);
        chk("seq_count", instr_count, 32'd3);
        // branch taken / not taken at 0x10
        fetch(32'hC, 32'h0);
        issue(1, 32'h10, 0, 0, 0, 0, 0);
        fetch(32'h10, 32'h1000_0001);
        issue(0, 0, 0, 1, 0, 1, 32'h40);
        fetch(32'h40, 32'h0);
        issue(1, 32'h10, 0, 0, 0, 0, 0);
        fetch(32'h10, 32'h1000_0001);
        issue(0, 0, 0, 1, 0, 0, 32'h40);
        // jal / jr
        fetch(32'h14, 32'h0);
        issue(1, 32'h0040_0000, 0, 0, 0, 0, 0);
        fetch(32'h0040_0000, 32'h0C00_0020);
        issue(0, 0, 1, 0, 0, 0, 0);
        chk("jal_link", link_addr, 32'h0040_0004);
        fetch(32'h80, 32'h0);
        issue(1, 32'h0040_0004, 0, 0, 0, 0, 0);
        chk("jr_link_kept", link_addr, 32'h0040_0004);
        chk("jr_count", instr_count, 32'd10);
        // ready low for 4 cycles, stray valid ignored
        imem_valid = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, 32'h0040_0004);
        end
        chk("stall_instr", Instruction, 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ready = 1'b0;
        imem_valid = 1'b0;
        chk("rv_ivalid", {31'd0, instr_valid}, 32'd1);
        chk("rv_instr", Instruction, 32'hCAFE_F00D);
        // hold with controls asserted
        hold = 1'b1;
        Jr = 1'b1;
        Read_data_1 = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ivalid", {31'd0, instr_valid}, 32'd1);
            chk("hold_count", instr_count, 32'd10);
            chk("hold_bba", branch_base_addr, 32'h0040_0008);
        end
        issue(0, 0, 0, 0, 0, 0, 0);
        chk("post_hold_count", instr_count, 32'd11);
        // PC wrap and forced alignment
        fetch(32'h0040_0008, 32'h0);
        issue(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        fetch(32'hFFFF_FFFC, 32'h0);
        chk("wrap_bba", branch_base_addr, 32'h0);
        issue(0, 0, 0, 0, 0, 0, 0);
        fetch(32'h0, 32'h0);
        issue(1, 32'h103, 0, 0, 0, 0, 0);
        chk("align_addr", imem_addr, 32'h100);
        // reset mid-WAIT, late valid ignored
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("w_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        chk("late_instr", Instruction, 32'h0);
        chk("late_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("late_req", {31'd0, imem_req}, 32'd1);
        chk("late_addr", imem_addr, 32'h0);
        chk("late_count", instr_count, 32'd0);
        tick();
        imem_valid = 1'b0;
        chk("late_instr2", Instruction, 32'h0);
        chk("late_link", link_addr, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
